uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

- Shares the single system UART transmit byte stream between `NumReq` requesters (e.g. software console, debug monitor, CHERI fault reporter).
- Sits between the requesters' byte sources and the UART TX byte interface that drives the serial line (`uart_tx_o`, read in simulation by the virtual UART).
- Round-robin arbitration with a one-deep registered output.
- Optional line locking keeps each requester's console lines from interleaving.

## Interface

- `NumReq`, default 2: number of requesters, 2..8.
- `LockTimeout`, default 1024: cycles a locked owner may stall with no valid byte before the lock is dropped. Must be ≥2; used only with line locking.

- `clk_i  in  1`: system clock.
- `rst_ni  in  1`: reset; asynchronous assert, active-low.
- `req_valid_i  in  NumReq`: per-requester byte valid.
- `req_data_i  in  8*NumReq`: per-requester byte; requester i uses bits [8i+7:8i].
- `req_ready_o  out  NumReq`: per-requester accept; at most one bit high in any cycle.
- `tx_valid_o  out  1`: output byte valid (registered).
- `tx_data_o  out  8`: output byte (registered).
- `tx_ready_i  in  1`: UART TX accepts the byte.
- `owner_o  out  $clog2(NumReq)`: current grant index; held at its last value while in IDLE.
- `busy_o  out  1`: high in state GRANT.
- `timeout_o  out  1`: one-cycle pulse when a lock times out.

## Operation

- Handshakes are valid/ready; a transfer occurs on a rising edge where both are high.
- Once valid is raised, the requester must hold it and its data stable until the byte is accepted. Violating this is a protocol error; behaviour is undefined.
- Output register:
  - Loads on a requester transfer.
  - Clears `tx_valid_o` on a `tx_valid_o && tx_ready_i` transfer that has no simultaneous load.
  - A simultaneous drain and load keeps `tx_valid_o` = 1 with the new data.
- FSM states:
  - IDLE: if any `req_valid_i` bit is set, grant the first requester found searching upward from `rr_ptr` with wrap (`rr_ptr`, `rr_ptr`+1, …, NumReq-1, 0, …). Set `owner` and go to GRANT. Otherwise stay in IDLE. All `req_ready_o` are 0.
  - GRANT: `req_ready_o[owner]` = `!tx_valid_o || tx_ready_i`. On an owner transfer, the release rule decides the next state.
- Release rule without line locking: every transfer returns the FSM to IDLE with `rr_ptr` = (owner+1) mod NumReq.
- Release rule with line locking:
  - A transfer of byte 0x0A returns to IDLE with `rr_ptr` = (owner+1) mod NumReq.
  - Any other byte stays in GRANT and resets the stall counter.
- Stall counter (line locking only):
  - Width `$clog2(LockTimeout)`.
  - Increments in GRANT on each cycle the owner's valid is low.
  - Does not increment while the owner is valid but blocked by `tx_ready_i`.
  - When it reaches LockTimeout-1 and the owner's valid is still low: pulse `timeout_o`, go to IDLE, set `rr_ptr` = owner+1, clear the counter.
- Non-owner valids are ignored in GRANT; a requester that drops valid is never penalised.
- `rr_ptr` wraps from NumReq-1 to 0.

## Timing

- Reset values:
  - State: IDLE.
  - `rr_ptr`, `owner_o`, counter: 0.
  - `tx_valid_o`, `tx_data_o`, `req_ready_o`, `busy_o`, `timeout_o`: 0.
- Reset asserted mid-transfer discards any held output byte immediately; the byte is lost.
- Latency with `tx_ready_i` = 1:
  - Cycle 0: valid seen in IDLE.
  - Cycle 1: GRANT with `req_ready_o` high; transfer at the end of the cycle.
  - Cycle 2: `tx_valid_o` high.
- Throughput:
  - Per-byte mode: one byte per 2 cycles.
  - Locked mode: one byte per cycle after grant.
- `timeout_o` rises in the same cycle the FSM enters IDLE.
- `busy_o` falls in that same cycle.

## Configuration

- Macro: `UART_ARB_LINE_LOCK_EN`.
- Defined:
  - Line locking, stall counter and `timeout_o` as described above.
- Undefined:
  - Pure per-byte round-robin.
  - Counter logic is removed.
  - `timeout_o` is tied to 0.
  - `LockTimeout` is ignored.

## Test plan

- Reset, then one requester: req0 sends 0x41 with `tx_ready_i` = 1 → `tx_valid_o` high 2 cycles after valid, `tx_data_o` = 0x41, `owner_o` = 0, `timeout_o` never pulses.
- Fairness, macro undefined: NumReq = 2, both requesters continuously valid with bytes 0x30 and 0x31 → output alternates 0x30, 0x31, 0x30, …
- Line lock, macro defined: req0 sends "AB\n", req1 valid throughout → output is 0x41 0x42 0x0A before any req1 byte.
- Lock timeout, macro defined, LockTimeout = 16: req0 sends 0x41 then drops valid, req1 valid → `timeout_o` pulses after 16 owner-idle cycles, then req1's byte follows.
- Backpressure: `tx_ready_i` held 0 for 20 cycles → exactly one byte is held, `req_ready_o` = 0 throughout, no data is lost or duplicated once ready rises.
- Reset mid-lock: assert `rst_ni` low while `busy_o` = 1 and `tx_valid_o` = 1 → all outputs read 0 on the same cycle, and arbitration restarts from `rr_ptr` = 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte stream between NumReq requesters.
// Define UART_ARB_LINE_LOCK_EN to hold a grant until 0x0A or a stall timeout.
module uart_tx_arbiter #(
    parameter int unsigned NumReq      = 2,
    parameter int unsigned LockTimeout = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumReq-1:0]         req_valid_i,
    input  logic [8*NumReq-1:0]       req_data_i,
    output logic [NumReq-1:0]         req_ready_o,
    output logic                      tx_valid_o,
    output logic [7:0]                tx_data_o,
    input  logic                      tx_ready_i,
    output logic [$clog2(NumReq)-1:0] owner_o,
    output logic                      busy_o,
    output logic                      timeout_o
);
    localparam int unsigned OwnW = $clog2(NumReq);
    localparam int unsigned SumW = OwnW + 1;

    typedef enum logic {IDLE, GRANT} state_e;

    state_e          state;
    logic [OwnW-1:0] rr_ptr;
    logic [OwnW-1:0] next_ptr;
    logic [NumReq-1:0] rot;
    logic            grant_found;
    logic [OwnW-1:0] grant_idx;
    logic [SumW-1:0] sum;
    logic            owner_valid;
    logic [7:0]      owner_data;
    logic            out_free;
    logic            xfer;

`ifdef UART_ARB_LINE_LOCK_EN
    localparam int unsigned CntW      = $clog2(LockTimeout);
    localparam logic [CntW-1:0] StallLast = CntW'(LockTimeout - 1);
    localparam logic [7:0] LineEnd    = 8'h0A;
    logic [CntW-1:0] stall_cnt;
`else
    logic [31:0] unused_lock_timeout;
    assign unused_lock_timeout = 32'(LockTimeout);
    assign timeout_o = 1'b0;
`endif

    assign owner_valid = req_valid_i[owner_o];
    assign owner_data  = req_data_i[{owner_o, 3'b000} +: 8];
    assign out_free    = !tx_valid_o || tx_ready_i;
    assign xfer        = (state == GRANT) && owner_valid && out_free;
    assign next_ptr    = (owner_o == OwnW'(NumReq - 1)) ? '0 : owner_o + OwnW'(1);

    // Rotate valids so bit 0 is rr_ptr; the first set bit is the round-robin winner.
    assign rot = NumReq'({req_valid_i, req_valid_i} >> rr_ptr);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!grant_found && rot[i]) begin
                grant_found = 1'b1;
                sum = SumW'(rr_ptr) + SumW'(i);
                if (sum >= SumW'(NumReq)) begin
                    sum = sum - SumW'(NumReq);
                end
                grant_idx = sum[OwnW-1:0];
            end
        end
    end

    // Only the owner sees ready, and only when the output slot can take a byte.
    always_comb begin
        req_ready_o = '0;
        if (state == GRANT) begin
            req_ready_o[owner_o] = out_free;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner_o    <= '0;
            busy_o     <= 1'b0;
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
`ifdef UART_ARB_LINE_LOCK_EN
            stall_cnt  <= '0;
            timeout_o  <= 1'b0;
`endif
        end else begin
            if (xfer) begin
                tx_valid_o <= 1'b1;
                tx_data_o  <= owner_data;
            end else if (tx_valid_o && tx_ready_i) begin
                tx_valid_o <= 1'b0;
            end
`ifdef UART_ARB_LINE_LOCK_EN
            timeout_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        state   <= GRANT;
                        busy_o  <= 1'b1;
                        owner_o <= grant_idx;
`ifdef UART_ARB_LINE_LOCK_EN
                        stall_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
`ifdef UART_ARB_LINE_LOCK_EN
                    // Lock holds until end of line; a silent owner is evicted after the timeout.
                    if (xfer) begin
                        stall_cnt <= '0;
                        if (owner_data == LineEnd) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            rr_ptr <= next_ptr;
                        end
                    end else if (!owner_valid) begin
                        if (stall_cnt == StallLast) begin
                            state     <= IDLE;
                            busy_o    <= 1'b0;
                            rr_ptr    <= next_ptr;
                            stall_cnt <= '0;
                            timeout_o <= 1'b1;
                        end else begin
                            stall_cnt <= stall_cnt + CntW'(1);
                        end
                    end
`else
                    if (xfer) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter; covers both UART_ARB_LINE_LOCK_EN builds.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned LOCK_TO = 16;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b1;
    logic [NREQ-1:0]   req_valid_i = '0;
    logic [8*NREQ-1:0] req_data_i = '0;
    logic [NREQ-1:0]   req_ready_o;
    logic              tx_valid_o;
    logic [7:0]        tx_data_o;
    logic              tx_ready_i = 1'b0;
    logic [0:0]        owner_o;
    logic              busy_o;
    logic              timeout_o;

    logic [7:0] src_q [NREQ][$];
    logic [7:0] exp_q [$];
    int n_total = 0;
    int n_bad   = 0;

    uart_tx_arbiter #(.NumReq(NREQ), .LockTimeout(LOCK_TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .owner_o(owner_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input int r, input logic [7:0] b);
        src_q[r].push_back(b);
    endtask

    task automatic sb_push(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic do_reset(input logic rdy);
        rst_ni = 1'b0;
        #1;
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        exp_q.delete();
        check("rst_tx_valid", 32'(tx_valid_o), 0);
        check("rst_tx_data", 32'(tx_data_o), 0);
        check("rst_req_ready", 32'(req_ready_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_timeout", 32'(timeout_o), 0);
        check("rst_owner", 32'(owner_o), 0);
        repeat (2) @(negedge clk_i);
        tx_ready_i = rdy;
        rst_ni = 1'b1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int cyc = 0;
        while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0)
               && cyc < budget) begin
            @(negedge clk_i);
            cyc++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 0);
        @(negedge clk_i);
        check({tag, "_no_dup"}, 32'(tx_valid_o), 0);
    endtask

    // Requester model: holds valid/data from its queue head until accepted.
    initial begin
        logic [NREQ-1:0]   acc;
        logic [NREQ-1:0]   nv;
        logic [8*NREQ-1:0] nd;
        forever begin
            @(negedge clk_i);
            acc = req_valid_i & req_ready_o;
            @(posedge clk_i);
            #1;
            nv = '0;
            nd = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    nv[i] = 1'b1;
                    nd[8*i +: 8] = src_q[i][0];
                end
            end
            req_valid_i = nv;
            req_data_i  = nd;
        end
    end

    // Output monitor: every accepted output byte is popped against the scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                check("ready_onehot", 32'($countones(req_ready_o) <= 1), 1);
`ifndef UART_ARB_LINE_LOCK_EN
                check("no_timeout", 32'(timeout_o), 0);
`endif
                if (tx_valid_o && tx_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("extra_byte", 32'(tx_data_o), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_data", 32'(tx_data_o), 32'(e));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        #1;
        do_reset(1'b1);

        // Single byte latency.
        send(0, 8'h41); sb_push(8'h41);
        @(posedge clk_i); #2;
        @(negedge clk_i);
        check("t1_c0_tx_valid", 32'(tx_valid_o), 0);
        check("t1_c0_busy", 32'(busy_o), 0);
        @(negedge clk_i);
        check("t1_c1_busy", 32'(busy_o), 1);
        check("t1_c1_ready", 32'(req_ready_o), 32'h1);
        @(negedge clk_i);
        check("t1_c2_tx_valid", 32'(tx_valid_o), 1);
        check("t1_c2_tx_data", 32'(tx_data_o), 32'h41);
        check("t1_c2_owner", 32'(owner_o), 0);
        wait_drain("t1", 20);

`ifndef UART_ARB_LINE_LOCK_EN
        // Fairness with both requesters saturated.
        do_reset(1'b1);
        for (int k = 0; k < 6; k++) begin
            send(0, 8'h30); send(1, 8'h31);
            sb_push(8'h30); sb_push(8'h31);
        end
        wait_drain("fair", 100);
`else
        // Line lock keeps req0's line together.
        do_reset(1'b1);
        send(0, 8'h41); send(0, 8'h42); send(0, 8'h0A);
        send(1, 8'h61); send(1, 8'h62); send(1, 8'h63);
        sb_push(8'h41); sb_push(8'h42); sb_push(8'h0A);
        sb_push(8'h61); sb_push(8'h62); sb_push(8'h63);
        wait_drain("lock", 100);

        // Stalled owner is evicted after LOCK_TO idle cycles.
        do_reset(1'b1);
        send(0, 8'h41); send(1, 8'h61);
        sb_push(8'h41); sb_push(8'h61);
        @(posedge clk_i); #2;
        c = 0;
        @(negedge clk_i);
        while (!timeout_o && c < 40) begin
            @(negedge clk_i);
            c++;
        end
        check("to_cycle", 32'(c), 2 + LOCK_TO);
        check("to_busy", 32'(busy_o), 0);
        @(negedge clk_i);
        check("to_pulse_width", 32'(timeout_o), 0);
        wait_drain("to", 100);
`endif

        // Backpressure: one byte held, nothing accepted, order preserved.
        do_reset(1'b0);
        send(0, 8'h50); send(0, 8'h51); send(0, 8'h0A); send(1, 8'h60);
`ifdef UART_ARB_LINE_LOCK_EN
        sb_push(8'h50); sb_push(8'h51); sb_push(8'h0A); sb_push(8'h60);
`else
        sb_push(8'h50); sb_push(8'h60); sb_push(8'h51); sb_push(8'h0A);
`endif
        @(posedge clk_i); #2;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (k >= 2) begin
                check("bp_tx_valid", 32'(tx_valid_o), 1);
                check("bp_tx_data", 32'(tx_data_o), 32'h50);
                check("bp_ready", 32'(req_ready_o), 0);
            end
        end
        @(posedge clk_i); #1;
        tx_ready_i = 1'b1;
        wait_drain("bp", 100);

        // Reset while granted with a byte held; arbitration restarts at req0.
        do_reset(1'b0);
        send(0, 8'h70); send(1, 8'h71); send(1, 8'h72);
        c = 0;
        @(negedge clk_i);
        while (!(busy_o && tx_valid_o) && c < 20) begin
            @(negedge clk_i);
            c++;
        end
        check("midrst_armed", 32'(busy_o && tx_valid_o), 1);
        #2;
        do_reset(1'b1);
        send(0, 8'h80); send(1, 8'h81);
        sb_push(8'h80); sb_push(8'h81);
        @(posedge clk_i); #2;
        @(negedge clk_i);
        @(negedge clk_i);
        check("restart_grant", 32'(req_ready_o), 32'h1);
        wait_drain("restart", 100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
